// File: rtl/log2_pipe.sv
// Three-stage pipelined base-2 logarithm: unsigned fixed-point in, signed fixed-point out.
// Zero input is flagged on out_zero and dout is forced to the most negative code.
module log2_pipe #(
    parameter int DIN_W    = 24,
    parameter int FRAC_IN  = 8,
    parameter int OUT_FRAC = 4,
    parameter int LUT_ADDR = 5,
    localparam int OUT_W   = $clog2(DIN_W) + 1 + OUT_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DIN_W-1:0] din,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic             out_zero
);

    localparam int PW    = $clog2(DIN_W);
    localparam int LUT_N = 1 << LUT_ADDR;
    localparam int FB    = 62;

    // Binary log digits by repeated squaring in Q2.62; one extra digit gives round-half-up.
    function automatic logic [OUT_FRAC-1:0] lut_entry(input int unsigned m);
        logic [63:0]  y;
        logic [127:0] sq;
        int unsigned  bits;
        y    = 64'(LUT_N + m) << (FB - LUT_ADDR);
        bits = 0;
        for (int unsigned i = 0; i < OUT_FRAC + 1; i++) begin
            sq   = 128'(y) * 128'(y);
            y    = 64'(sq >> FB);
            bits = (bits << 1) | 32'(y[FB+1]);
            if (y[FB+1]) begin
                y = y >> 1;
            end
        end
        bits = (bits + 1) >> 1;
        if (bits > 32'((1 << OUT_FRAC) - 1)) begin
            bits = 32'((1 << OUT_FRAC) - 1);
        end
        return OUT_FRAC'(bits);
    endfunction

    function automatic logic [LUT_N*OUT_FRAC-1:0] lut_table();
        logic [LUT_N*OUT_FRAC-1:0] t;
        t = '0;
        for (int unsigned m = 0; m < LUT_N; m++) begin
            t[m*OUT_FRAC +: OUT_FRAC] = lut_entry(m);
        end
        return t;
    endfunction

    localparam logic [LUT_N*OUT_FRAC-1:0] LUT_TBL = lut_table();

    logic                v1_q, v2_q, v3_q;
    logic [DIN_W-1:0]    d1_q;
    logic [PW-1:0]       p_d, p2_q;
    logic [LUT_ADDR-1:0] m_d, m2_q;
    logic                z_d, z2_q;
    logic [OUT_FRAC-1:0] frac;
    logic [OUT_W-1:0]    dout_d, dout_q;
    logic                zero_q;

    // Stage 2: MSB position, left-aligned mantissa (low bits zero-filled by the shift), zero flag.
    always_comb begin
        p_d = '0;
        for (int unsigned i = 0; i < DIN_W; i++) begin
            if (d1_q[i]) begin
                p_d = PW'(i);
            end
        end
        m_d = LUT_ADDR'((d1_q << (PW'(DIN_W - 1) - p_d)) >> (DIN_W - 1 - LUT_ADDR));
        z_d = (d1_q == '0);
    end

    always_comb begin
        frac   = LUT_TBL[int'(m2_q)*OUT_FRAC +: OUT_FRAC];
        dout_d = OUT_W'((int'(p2_q) - FRAC_IN) * (2 ** OUT_FRAC) + int'(frac));
        if (z2_q) begin
            dout_d = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            d1_q   <= '0;
            p2_q   <= '0;
            m2_q   <= '0;
            z2_q   <= 1'b0;
            dout_q <= '0;
            zero_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                d1_q <= din;
            end
            if (v1_q) begin
                p2_q <= p_d;
                m2_q <= m_d;
                z2_q <= z_d;
            end
            if (v2_q) begin
                dout_q <= dout_d;
                zero_q <= z2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign dout      = dout_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_log2_pipe.sv
// Scoreboard bench for log2_pipe: default instance plus a 16-bit / 6-frac-bit instance.
module tb_log2_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        va = 1'b0;
    logic [23:0] da = '0;
    logic        ova, za;
    logic [9:0]  douta;
    logic        vb = 1'b0;
    logic [15:0] db = '0;
    logic        ovb, zb;
    logic [10:0] doutb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int prev_a = 0;
    int prev_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   d;
        logic z;
        int   mono;
        int   t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    log2_pipe u_a (
        .clk(clk), .rst(rst), .in_valid(va), .din(da),
        .out_valid(ova), .dout(douta), .out_zero(za)
    );

    log2_pipe #(.DIN_W(16), .FRAC_IN(0), .OUT_FRAC(6), .LUT_ADDR(7)) u_b (
        .clk(clk), .rst(rst), .in_valid(vb), .din(db),
        .out_valid(ovb), .dout(doutb), .out_zero(zb)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model(input longint din, input int dinw, input int fin, input int of,
                                  input int la, output int d, output logic z);
        int     p;
        int     f;
        longint m;
        real    r;
        z = (din == 0);
        if (z) begin
            d = -(1 << ($clog2(dinw) + of));
            return;
        end
        p = 0;
        for (int i = 0; i < dinw; i++) if (din[i]) p = i;
        m = ((din << (dinw - 1 - p)) >> (dinw - 1 - la)) & ((64'sd1 << la) - 1);
        r = $ln(1.0 + real'(m) / real'(64'sd1 << la)) / $ln(2.0) * real'(1 << of);
        f = int'($floor(r + 0.5));
        if (f > (1 << of) - 1) f = (1 << of) - 1;
        d = (p - fin) * (1 << of) + f;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_a(input logic v, input logic [23:0] d, input int e, input logic z, input int mono);
        va = v;
        da = d;
        if (v) qa.push_back('{e, z, mono, cyc});
    endtask

    task automatic push_b(input logic v, input logic [15:0] d, input int e, input logic z, input int mono);
        vb = v;
        db = d;
        if (v) qb.push_back('{e, z, mono, cyc});
    endtask

    task automatic auto_a(input logic v, input logic [23:0] d, input int mono);
        int e; logic z;
        model(longint'(d), 24, 8, 4, 5, e, z);
        push_a(v, d, e, z, mono);
    endtask

    task automatic auto_b(input logic v, input logic [15:0] d, input int mono);
        int e; logic z;
        model(longint'(d), 16, 0, 6, 7, e, z);
        push_b(v, d, e, z, mono);
    endtask

    task automatic wait_drain();
        va = 1'b0;
        vb = 1'b0;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && ova) begin
            if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_dout", int'($signed(douta)), ea.d);
                chk("a_zero", int'(za), int'(ea.z));
                chk("a_latency", cyc - ea.t, 3);
                if (ea.mono == 2) begin
                    checks++;
                    if (int'($signed(douta)) < prev_a) begin
                        errors++;
                        $display("FAIL a_monotonic: got %0d, required >= %0d", $signed(douta), prev_a);
                    end
                end
                if (ea.mono != 0) prev_a = int'($signed(douta));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ovb) begin
            if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_dout", int'($signed(doutb)), eb.d);
                chk("b_zero", int'(zb), int'(eb.z));
                chk("b_latency", cyc - eb.t, 3);
                if (eb.mono == 2) begin
                    checks++;
                    if (int'($signed(doutb)) < prev_b) begin
                        errors++;
                        $display("FAIL b_monotonic: got %0d, required >= %0d", $signed(doutb), prev_b);
                    end
                end
                if (eb.mono != 0) prev_b = int'($signed(doutb));
            end
        end
    end

    logic [23:0] dir_da [11] = '{24'h000100, 24'h000300, 24'hFFFFFF, 24'h000080, 24'h000001,
                                 24'h000000, 24'h000200, 24'h000180, 24'h000002, 24'h000000,
                                 24'h000100};
    int          dir_ea [11] = '{0, 25, 255, -16, -128, -512, 16, 9, -112, -512, 0};
    logic [15:0] dir_db [6]  = '{16'h0001, 16'h0003, 16'hFFFF, 16'h0000, 16'h8000, 16'h0002};
    int          dir_eb [6]  = '{0, 101, 1023, -1024, 960, 64};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        logic [23:0] d;
        logic [15:0] d2;
        logic v;

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_a_valid", int'(ova), 0);
        chk("rst_a_dout", int'(douta), 0);
        chk("rst_a_zero", int'(za), 0);
        chk("rst_b_valid", int'(ovb), 0);
        chk("rst_b_dout", int'(doutb), 0);
        chk("rst_b_zero", int'(zb), 0);
        #4 rst = 1'b0;
        repeat (4) begin
            tick();
            chk("idle_a_valid", int'(ova), 0);
            chk("idle_a_dout", int'(douta), 0);
            chk("idle_a_zero", int'(za), 0);
        end

        for (int i = 0; i < 11; i++) begin
            tick();
            push_a(1'b1, dir_da[i], dir_ea[i], dir_da[i] == 24'h0, 0);
            if (i < 6) push_b(1'b1, dir_db[i], dir_eb[i], dir_db[i] == 16'h0, 0);
            else push_b(1'b0, '0, 0, 1'b0, 0);
        end
        tick();
        wait_drain();

        for (int i = 0; i < 1000; i++) begin
            tick();
            v = (i % 97 < 85) && ($urandom_range(0, 3) != 0);
            p = $urandom_range(0, 23);
            d = 24'((1 << p) | ($urandom & ((1 << p) - 1)));
            if ($urandom_range(0, 49) == 0) d = '0;
            auto_a(v, d, 0);
            v = ($urandom_range(0, 2) != 0);
            p = $urandom_range(0, 15);
            d2 = 16'((1 << p) | ($urandom & ((1 << p) - 1)));
            if ($urandom_range(0, 49) == 0) d2 = '0;
            auto_b(v, d2, 0);
        end

        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                auto_a(1'b1, 24'((1 << i) + (((1 << i) * j) >> 2)), (i == 0 && j == 0) ? 1 : 2);
                if (i < 16) auto_b(1'b1, 16'((1 << i) + (((1 << i) * j) >> 2)), (i == 0 && j == 0) ? 1 : 2);
                else push_b(1'b0, '0, 0, 1'b0, 0);
            end
        end
        tick();
        wait_drain();

        // Reset while three samples occupy the pipeline.
        tick(); auto_a(1'b1, 24'h000300, 0); auto_b(1'b1, 16'd3, 0);
        tick(); auto_a(1'b1, 24'h001000, 0); auto_b(1'b1, 16'd100, 0);
        tick(); auto_a(1'b1, 24'h000000, 0); auto_b(1'b1, 16'd0, 0);
        tick(); va = 1'b0; vb = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_a_valid", int'(ova), 0);
        chk("midrst_b_valid", int'(ovb), 0);
        qa.delete();
        qb.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("post_rst_a_valid", int'(ova), 0);
            chk("post_rst_b_valid", int'(ovb), 0);
        end
        tick();
        push_a(1'b1, 24'h000080, -16, 1'b0, 0);
        push_b(1'b1, 16'h8000, 960, 1'b0, 0);
        tick();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log2_pipe.md
# log2_pipe

Parametrised, fully pipelined base-2 logarithm unit with valid tracking and signed output. It accepts one fixed-point unsigned sample per cycle and returns a signed fixed-point log2 three cycles later. Unlike the previous fixed 24-in/8-out unit, it also handles inputs below 1.0 (negative logs) and flags zero input. It sits in the arithmetic datapath wherever dB/log-domain scaling is needed ahead of compare or accumulate stages.

## Interface
- `DIN_W`, 24: input width in bits (≥ 8).
- `FRAC_IN`, 8: input binary-point position (fractional bits of `din`), 0 ≤ FRAC_IN < DIN_W.
- `OUT_FRAC`, 4: fractional bits of `dout`.
- `LUT_ADDR`, 5: mantissa bits used to address the fraction LUT (table depth 2^LUT_ADDR).
- Derived: `OUT_W` = $clog2(DIN_W) + 1 + OUT_FRAC, which is 10 at the defaults.

- `clk` in 1: clock, all registers on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: `din` is valid this cycle.
- `din` in DIN_W: unsigned input, value = din / 2^FRAC_IN.
- `out_valid` out 1: `dout` and `out_zero` are valid.
- `dout` out OUT_W: signed two's-complement log2, value = dout / 2^OUT_FRAC.
- `out_zero` out 1: the input was zero. `dout` is then forced to the most negative code.

## Operation
- Pipeline has three register stages and no backpressure. It accepts one sample per cycle, and bubbles (`in_valid`=0) propagate as `out_valid`=0.
- Stage 1: register `din` and `in_valid`.
- Stage 2:
  - Priority-encode the MSB position p (0..DIN_W-1) and register p.
  - Left-align the bits below p, take the top LUT_ADDR bits as mantissa m, and register m. When p < LUT_ADDR, zero-fill the missing low bits.
  - Register zero = (din == 0).
- Stage 3:
  - frac = LUT[m], where LUT[m] = min(round_half_up(log2(1 + m/2^LUT_ADDR) · 2^OUT_FRAC), 2^OUT_FRAC − 1).
  - dout = ((p − FRAC_IN) << OUT_FRAC) + frac, sign-extended to OUT_W.
  - If zero: dout = −2^(OUT_W−1) and out_zero = 1; otherwise out_zero = 0.
- LUT contents are constants fixed at elaboration from the formula above. The implementation chooses between a constant function and a generated include. The bench model uses the same formula.
- Integer part p − FRAC_IN ranges from −FRAC_IN to DIN_W−1−FRAC_IN and always fits OUT_W without overflow.
- The output is monotonic non-decreasing in `din` for all nonzero inputs. This follows from the LUT being monotonic and from the clamp.
- Data registers update only when the corresponding stage valid is set. With no valid data, `dout`/`out_zero` hold their last value.

## Timing
- Latency is exactly 3 cycles: a sample taken at rising edge N with `in_valid`=1 appears on `dout`/`out_valid` after edge N+3.
- Throughput is one result per cycle. Back-to-back samples come out in order with no gaps.
- Reset values: `out_valid`=0, `dout`=0, `out_zero`=0, and all internal valid bits 0. Data registers are also reset to 0.
- Reset asserted mid-stream:
  - All in-flight samples are discarded and `out_valid` drops immediately (asynchronous).
  - After deassertion, the first valid output is the first sample accepted after reset, 3 cycles later.
- `in_valid` toggling every cycle gives `out_valid` toggling with the same pattern, delayed by 3.
- No combinational path from any input to any output.

## Test plan
Scenarios use the default parameters (OUT_W = 10).
- Reset then idle: assert `rst` asynchronously mid-cycle, then release -> `out_valid`=0, `dout`=0x000, `out_zero`=0 with no clock edge needed. Outputs stay there while `in_valid`=0.
- Known points:
  - din=0x000100 (1.0) -> dout=0x000.
  - din=0x000300 (3.0) -> dout=25 (0x019), from 1·16 + round(9.36).
  - din=0xFFFFFF -> dout=255 (0x0FF), because the LUT clamps at 15.
- Values below 1.0:
  - din=0x000080 (0.5) -> dout=−16 (0x3F0).
  - din=0x000001 -> dout=−128 (0x380). This exercises the zero-fill path where p < LUT_ADDR.
- Zero input: din=0 with `in_valid`=1 -> `out_zero`=1, dout=−512 (0x200). The next nonzero sample must clear `out_zero`.
- Streaming and bubbles: feed 1000 random samples with random `in_valid`, including runs of 0 and sweeps across every MSB position -> every valid output matches the model exactly at latency 3, in order, and the output is monotonic over a sorted sweep.
- Reset mid-stream: assert `rst` with 3 samples in flight -> no stale `out_valid` after release. Then do the same at non-default parameters (DIN_W=16, FRAC_IN=0, OUT_FRAC=6, LUT_ADDR=7) against the model.
